// File: rtl/main_fsm_controller_pkg.sv
// Shared constants for the multicycle RISC-V main controller: state
// encoding, ALU operation codes, datapath mux selects and opcodes.
package main_fsm_controller_pkg;

  // FSM state encoding (4-bit, kept as plain constants for legacy tools)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_JALR2    = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // Class of ALU decode requested by the FSM
  typedef enum logic [1:0] {
    CLASS_ADD = 2'b00,
    CLASS_SUB = 2'b01,
    CLASS_R   = 2'b10,
    CLASS_I   = 2'b11
  } alu_class_t;

  // Mux select encodings
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_A      = 2'b10;
  localparam logic [1:0] SRCB_WDATA  = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;
  localparam logic [1:0] IMM_I       = 2'b00;
  localparam logic [1:0] IMM_S       = 2'b01;
  localparam logic [1:0] IMM_B       = 2'b10;
  localparam logic [1:0] IMM_J       = 2'b11;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  // Opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Branch condition from the SUB flags of rs1 - rs2
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic cout, input logic overflow,
                                        input logic sign);
    logic taken;
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = sign ^ overflow;
      3'b101:  taken = !(sign ^ overflow);
      3'b110:  taken = !cout;
      3'b111:  taken = cout;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/main_fsm_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's requested class plus
// funct3/funct7 onto an ALU operation code.
module alu_decoder
  import main_fsm_controller_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7,
  output logic [3:0]  alu_control
);

  // R-type honours funct7 for SUB/SRA; I-type only for SRAI
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      CLASS_ADD: alu_control = ALU_ADD;
      CLASS_SUB: alu_control = ALU_SUB;
      CLASS_R, CLASS_I: begin
        case (funct3)
          3'b000:  alu_control = (alu_class == CLASS_R && funct7) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/main_fsm_controller.sv
// Moore main controller for a multicycle RISC-V datapath. Sequences
// fetch/decode/execute/writeback and traps on unknown opcodes.
module main_fsm_controller
  import main_fsm_controller_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       cout,
  input  logic       overflow,
  input  logic       sign,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic [2:0] size,
  output logic       halted,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] next_state;
  alu_class_t alu_class;
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       ir_write_raw;

  // State register; reset wins from any state, even mid-instruction
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= S_FETCH;
    else        state_q <= next_state;
  end

  // Per-state outputs and next-state selection
  always_comb begin
    next_state    = state_q;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_WDATA;
    ImmSrc        = IMM_I;
    ResultSrc     = RES_ALUOUT;
    AdrSrc        = 1'b0;
    alu_class     = CLASS_ADD;
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    size          = SIZE_WORD;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURES;
        pc_write_raw = 1'b1;
        next_state   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (OP == OP_JAL) ? IMM_J : IMM_B;
        case (OP)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          default:           next_state = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = (OP == OP_STORE) ? IMM_S : IMM_I;
        next_state = (OP == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc     = 1'b1;
        size       = funct3;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
        size          = funct3;
        next_state    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        size          = funct3;
        next_state    = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_A;
        alu_class  = CLASS_R;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        alu_class  = CLASS_I;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        next_state    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA      = SRCA_A;
        alu_class    = CLASS_SUB;
        pc_write_raw = branch_taken(funct3, Zero, cout, overflow, sign);
        next_state   = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
        next_state   = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        next_state = S_JALR2;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_HALT;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (ALUControl)
  );

  // Architectural enables and the trap flag are suppressed while reset is held
  always_comb begin
    PCWrite  = pc_write_raw  & RESET;
    MemWrite = mem_write_raw & RESET;
    RegWrite = reg_write_raw & RESET;
    IRWrite  = ir_write_raw  & RESET;
    halted   = (state_q == S_HALT) & RESET;
  end

  assign state = state_q;

endmodule

// File: tb/tb_main_fsm_controller.sv
// Directed self-checking bench for main_fsm_controller.
module tb_main_fsm_controller;
  import main_fsm_controller_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [6:0] OP = '0;
  logic [2:0] funct3 = '0;
  logic       funct7 = 1'b0;
  logic       Zero = 1'b0, cout = 1'b0, overflow = 1'b0, sign = 1'b0;
  logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
  logic [3:0] ALUControl;
  logic       AdrSrc, PCWrite, MemWrite, RegWrite, IRWrite;
  logic [2:0] size;
  logic       halted;
  logic [3:0] state;

  int passCount = 0;
  int checkCount = 0;

  main_fsm_controller dut (
    .CLK(CLK), .RESET(RESET), .OP(OP), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .cout(cout), .overflow(overflow), .sign(sign),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .AdrSrc(AdrSrc), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .size(size), .halted(halted), .state(state)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Drive inputs after a falling edge and let combinational outputs settle
  task automatic applyStimulus(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic [3:0] flags);
    @(negedge CLK);
    RESET = rst; OP = op; funct3 = f3; funct7 = f7;
    {Zero, cout, overflow, sign} = flags;
    #1;
  endtask

  // State plus {PCWrite, MemWrite, RegWrite, IRWrite}
  task automatic checkCore(input string tag, input logic [3:0] st, input logic [3:0] en);
    checkOutput({tag, "_state"}, 32'(state), 32'(st));
    checkOutput({tag, "_en"}, 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'(en));
  endtask

  // FETCH then DECODE of a new instruction
  task automatic runPrologue(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [3:0] flags);
    applyStimulus(1'b1, op, f3, f7, flags);
    checkCore({tag, "_fetch"}, 4'd0, 4'b1001);
    applyStimulus(1'b1, op, f3, f7, flags);
    checkCore({tag, "_decode"}, 4'd1, 4'b0000);
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset holds FETCH but suppresses its enables
    applyStimulus(1'b0, 7'd0, 3'd0, 1'b0, 4'b0000);
    checkCore("rst", 4'd0, 4'b0000);
    checkOutput("rst_halted", 32'(halted), 32'd0);

    // ADD x3,x1,x2
    applyStimulus(1'b1, 7'b0110011, 3'b000, 1'b0, 4'b0000);
    checkCore("add_fetch", 4'd0, 4'b1001);
    checkOutput("add_fetch_srcb", 32'(ALUSrcB), 32'd2);
    checkOutput("add_fetch_res", 32'(ResultSrc), 32'd2);
    checkOutput("add_fetch_size", 32'(size), 32'd2);
    checkOutput("add_fetch_alu", 32'(ALUControl), 32'd0);
    applyStimulus(1'b1, 7'b0110011, 3'b000, 1'b0, 4'b0000);
    checkCore("add_decode", 4'd1, 4'b0000);
    checkOutput("add_decode_srca", 32'(ALUSrcA), 32'd1);
    checkOutput("add_decode_imm", 32'(ImmSrc), 32'd2);
    applyStimulus(1'b1, 7'b0110011, 3'b000, 1'b0, 4'b0000);
    checkCore("add_exec", 4'd6, 4'b0000);
    checkOutput("add_exec_alu", 32'(ALUControl), 32'd0);
    checkOutput("add_exec_srca", 32'(ALUSrcA), 32'd2);
    applyStimulus(1'b1, 7'b0110011, 3'b000, 1'b0, 4'b0000);
    checkCore("add_wb", 4'd8, 4'b0010);

    // SUB (R-type funct7=1)
    runPrologue("sub", 7'b0110011, 3'b000, 1'b1, 4'b0000);
    applyStimulus(1'b1, 7'b0110011, 3'b000, 1'b1, 4'b0000);
    checkOutput("sub_alu", 32'(ALUControl), 32'd1);
    applyStimulus(1'b1, 7'b0110011, 3'b000, 1'b1, 4'b0000);
    checkCore("sub_wb", 4'd8, 4'b0010);

    // SLTU R-type
    runPrologue("sltu", 7'b0110011, 3'b011, 1'b0, 4'b0000);
    applyStimulus(1'b1, 7'b0110011, 3'b011, 1'b0, 4'b0000);
    checkOutput("sltu_alu", 32'(ALUControl), 32'd6);
    applyStimulus(1'b1, 7'b0110011, 3'b011, 1'b0, 4'b0000);

    // SRAI: funct7 honoured
    runPrologue("srai", 7'b0010011, 3'b101, 1'b1, 4'b0000);
    applyStimulus(1'b1, 7'b0010011, 3'b101, 1'b1, 4'b0000);
    checkCore("srai_exec", 4'd7, 4'b0000);
    checkOutput("srai_alu", 32'(ALUControl), 32'd9);
    checkOutput("srai_srcb", 32'(ALUSrcB), 32'd1);
    applyStimulus(1'b1, 7'b0010011, 3'b101, 1'b1, 4'b0000);

    // ADDI with funct7 bit set must still add
    runPrologue("addi", 7'b0010011, 3'b000, 1'b1, 4'b0000);
    applyStimulus(1'b1, 7'b0010011, 3'b000, 1'b1, 4'b0000);
    checkOutput("addi_alu", 32'(ALUControl), 32'd0);
    applyStimulus(1'b1, 7'b0010011, 3'b000, 1'b1, 4'b0000);
    checkCore("addi_wb", 4'd8, 4'b0010);

    // LW: five cycles
    runPrologue("lw", 7'b0000011, 3'b010, 1'b0, 4'b0000);
    applyStimulus(1'b1, 7'b0000011, 3'b010, 1'b0, 4'b0000);
    checkCore("lw_adr", 4'd2, 4'b0000);
    checkOutput("lw_adr_imm", 32'(ImmSrc), 32'd0);
    applyStimulus(1'b1, 7'b0000011, 3'b010, 1'b0, 4'b0000);
    checkCore("lw_read", 4'd3, 4'b0000);
    checkOutput("lw_read_adrsrc", 32'(AdrSrc), 32'd1);
    applyStimulus(1'b1, 7'b0000011, 3'b010, 1'b0, 4'b0000);
    checkCore("lw_wb", 4'd4, 4'b0010);
    checkOutput("lw_wb_res", 32'(ResultSrc), 32'd1);
    checkOutput("lw_wb_size", 32'(size), 32'd2);

    // SB: byte store, no register write
    runPrologue("sb", 7'b0100011, 3'b000, 1'b0, 4'b0000);
    applyStimulus(1'b1, 7'b0100011, 3'b000, 1'b0, 4'b0000);
    checkCore("sb_adr", 4'd2, 4'b0000);
    checkOutput("sb_adr_imm", 32'(ImmSrc), 32'd1);
    applyStimulus(1'b1, 7'b0100011, 3'b000, 1'b0, 4'b0000);
    checkCore("sb_write", 4'd5, 4'b0100);
    checkOutput("sb_write_size", 32'(size), 32'd0);
    checkOutput("sb_write_adrsrc", 32'(AdrSrc), 32'd1);

    // BLT sign=1 overflow=0 taken; flags order {Zero,cout,overflow,sign}
    runPrologue("blt1", 7'b1100011, 3'b100, 1'b0, 4'b0001);
    applyStimulus(1'b1, 7'b1100011, 3'b100, 1'b0, 4'b0001);
    checkCore("blt1_br", 4'd9, 4'b1000);
    checkOutput("blt1_alu", 32'(ALUControl), 32'd1);
    // BLT sign=1 overflow=1 not taken
    runPrologue("blt2", 7'b1100011, 3'b100, 1'b0, 4'b0011);
    applyStimulus(1'b1, 7'b1100011, 3'b100, 1'b0, 4'b0011);
    checkCore("blt2_br", 4'd9, 4'b0000);
    // BLTU cout=0 taken
    runPrologue("bltu", 7'b1100011, 3'b110, 1'b0, 4'b0000);
    applyStimulus(1'b1, 7'b1100011, 3'b110, 1'b0, 4'b0000);
    checkCore("bltu_br", 4'd9, 4'b1000);
    // BNE with Zero=1 not taken
    runPrologue("bne", 7'b1100011, 3'b001, 1'b0, 4'b1000);
    applyStimulus(1'b1, 7'b1100011, 3'b001, 1'b0, 4'b1000);
    checkCore("bne_br", 4'd9, 4'b0000);
    // funct3=010 never taken
    runPrologue("b010", 7'b1100011, 3'b010, 1'b0, 4'b1111);
    applyStimulus(1'b1, 7'b1100011, 3'b010, 1'b0, 4'b1111);
    checkCore("b010_br", 4'd9, 4'b0000);

    // JAL
    applyStimulus(1'b1, 7'b1101111, 3'b000, 1'b0, 4'b0000);
    checkCore("jal_fetch", 4'd0, 4'b1001);
    applyStimulus(1'b1, 7'b1101111, 3'b000, 1'b0, 4'b0000);
    checkOutput("jal_decode_imm", 32'(ImmSrc), 32'd3);
    applyStimulus(1'b1, 7'b1101111, 3'b000, 1'b0, 4'b0000);
    checkCore("jal_jal", 4'd10, 4'b1000);
    checkOutput("jal_srca", 32'(ALUSrcA), 32'd1);
    checkOutput("jal_srcb", 32'(ALUSrcB), 32'd2);
    applyStimulus(1'b1, 7'b1101111, 3'b000, 1'b0, 4'b0000);
    checkCore("jal_wb", 4'd8, 4'b0010);

    // JALR
    runPrologue("jalr", 7'b1100111, 3'b000, 1'b0, 4'b0000);
    applyStimulus(1'b1, 7'b1100111, 3'b000, 1'b0, 4'b0000);
    checkCore("jalr_1", 4'd11, 4'b0000);
    checkOutput("jalr_1_srcb", 32'(ALUSrcB), 32'd1);
    applyStimulus(1'b1, 7'b1100111, 3'b000, 1'b0, 4'b0000);
    checkCore("jalr_2", 4'd12, 4'b1000);
    applyStimulus(1'b1, 7'b1100111, 3'b000, 1'b0, 4'b0000);
    checkCore("jalr_wb", 4'd8, 4'b0010);

    // Reset asserted during MEMWRITE
    runPrologue("sbr", 7'b0100011, 3'b000, 1'b0, 4'b0000);
    applyStimulus(1'b1, 7'b0100011, 3'b000, 1'b0, 4'b0000);
    applyStimulus(1'b0, 7'b0100011, 3'b000, 1'b0, 4'b0000);
    checkCore("sbr_write", 4'd5, 4'b0000);
    applyStimulus(1'b0, 7'b0100011, 3'b000, 1'b0, 4'b0000);
    checkCore("sbr_after", 4'd0, 4'b0000);

    // Illegal opcode traps into HALT
    runPrologue("ill", 7'b1111111, 3'b000, 1'b0, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 7'b1111111, 3'b000, 1'b0, 4'b1111);
      checkCore("ill_halt", 4'd13, 4'b0000);
      checkOutput("ill_halted", 32'(halted), 32'd1);
    end
    applyStimulus(1'b0, 7'b1111111, 3'b000, 1'b0, 4'b0000);
    checkOutput("ill_rst_halted", 32'(halted), 32'd0);
    applyStimulus(1'b0, 7'b1111111, 3'b000, 1'b0, 4'b0000);
    checkCore("ill_rst", 4'd0, 4'b0000);
    applyStimulus(1'b1, 7'b0110011, 3'b000, 1'b0, 4'b0000);
    checkCore("post_fetch", 4'd0, 4'b1001);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/main_fsm_controller.md
MAIN_FSM_CONTROLLER -- requirements
Module: main_fsm_controller

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RESET  in  1  synchronous, active-low reset; sampled on CLK rising edge.
REQ-003 OP  in  7  opcode (Instr[6:0]); funct3  in  3  Instr[14:12]; funct7  in  1  Instr[30].
REQ-004 Zero, cout, overflow, sign  in  1 each  ALU flags for the current-cycle ALUResult.
REQ-005 ALUSrcA, ALUSrcB, ImmSrc, ResultSrc  out  2 each  datapath mux selects.
REQ-006 ALUControl  out  4  ALU op; AdrSrc, PCWrite, MemWrite, RegWrite, IRWrite  out  1 each.
REQ-007 size  out  3  memory access size; halted  out  1  illegal-opcode trap flag; state  out  4  debug.

Function
REQ-008 Encodings: ALUSrcA 00=PC, 01=OldPC, 10=A; ALUSrcB 00=WriteData, 01=ImmExt, 10=4; ResultSrc 00=ALUOut, 01=Data, 10=ALUResult; AdrSrc 0=PC, 1=Result; ImmSrc 00=I, 01=S, 10=B, 11=J.
REQ-009 ALUControl: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
REQ-010 Moore FSM; all outputs a function of state, plus OP/funct3/funct7/flags only where stated; unlisted enables 0, unlisted selects 00.
REQ-011 FETCH: AdrSrc=0, IRWrite=1, SrcA=PC, SrcB=4, ADD, ResultSrc=10, PCWrite=1, size=010; next DECODE.
REQ-012 DECODE: SrcA=OldPC, SrcB=ImmExt, ADD, ImmSrc=11 if OP=1101111 else 10; next by OP: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, other->HALT.
REQ-013 MEMADR: SrcA=A, SrcB=ImmExt, ADD, ImmSrc=01 if store else 00; next MEMREAD (load) or MEMWRITE (store).
REQ-014 MEMREAD: AdrSrc=1, ResultSrc=00, size=funct3; next MEMWB. MEMWB: ResultSrc=01, RegWrite=1, size=funct3; next FETCH.
REQ-015 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, size=funct3; next FETCH.
REQ-016 EXECR: SrcA=A, SrcB=WriteData, ALUControl from funct3/funct7 (000 with funct7=1 -> SUB); next ALUWB.
REQ-017 EXECI: SrcA=A, SrcB=ImmExt, ImmSrc=00; funct7 honoured only for funct3=101 (SRAI); funct3=000 always ADD; next ALUWB.
REQ-018 ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-019 BRANCH: SrcA=A, SrcB=WriteData, SUB, ResultSrc=00; PCWrite=taken; next FETCH.
REQ-020 Taken: BEQ Zero; BNE !Zero; BLT sign^overflow; BGE !(sign^overflow); BLTU !cout; BGEU cout; funct3 010/011 -> not taken.
REQ-021 JAL: SrcA=OldPC, SrcB=4, ADD, ResultSrc=00, PCWrite=1; next ALUWB (rd=OldPC+4).
REQ-022 JALR: SrcA=A, SrcB=ImmExt, ImmSrc=00, ADD; next JALR2. JALR2: as JAL state; next ALUWB; target bit 0 not cleared.
REQ-023 Latency (cycles incl. FETCH): R/I 4, load 5, store 4, branch 3, JAL 4, JALR 5.
REQ-024 HALT: all enables 0, halted=1; exits only via reset.
REQ-025 size=010 in every state not listed in REQ-014/015.

Reset
REQ-026 RESET low at a rising edge -> state=FETCH at next cycle, regardless of current state (mid-instruction included).
REQ-027 While RESET is low, PCWrite, MemWrite, RegWrite, IRWrite forced 0 combinationally; halted=0.
REQ-028 First cycle after RESET deasserts executes FETCH.

Structure
REQ-029 Shared package holds state encoding (4-bit), ALUControl codes, mux-select constants, opcode constants.
REQ-030 Sub-module alu_decoder: inputs state-class (R/I/ADD/SUB), funct3, funct7 -> ALUControl; combinational only.

Verification
REQ-031 Reset then ADD x3,x1,x2 (OP=0110011, f3=000, f7=0) -> states FETCH,DECODE,EXECR,ALUWB; ALUControl=0000; RegWrite=1 only in 4th cycle.
REQ-032 LW (OP=0000011, f3=010) -> 5 cycles; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1, size=010.
REQ-033 SB (OP=0100011, f3=000) -> MEMADR ImmSrc=01; MEMWRITE MemWrite=1, size=000; no RegWrite.
REQ-034 BLT f3=100, sign=1, overflow=0 -> PCWrite=1 in BRANCH; repeat with overflow=1 -> PCWrite=0; BLTU cout=0 -> taken.
REQ-035 OP=1111111 -> HALT, halted=1, zero enables for 20 cycles; RESET low -> FETCH.
REQ-036 RESET low during MEMWRITE -> MemWrite=0 that cycle; FETCH next cycle.
